// File: rtl/keypad_scanner_if.sv
// ============================================================================
// Module      : keypad_scanner_if
// Description : Key-matrix and hex-entry signal bundle shared by the keypad
//               scanner (slave) and the board / environment side (master).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
  logic [3:0]  rows;        // matrix row lines, active-low, pulled up
  logic        clearEntry;  // synchronous clear of entryValue
  logic [3:0]  cols;        // column drive, active-low one-hot
  logic [3:0]  keyCode;     // {rowIdx, colIdx} of last accepted key
  logic        keyValid;    // one-clock pulse per accepted press
  logic        keyHeld;     // accepted key still considered pressed
  logic [15:0] entryValue;  // last four accepted codes, newest in [3:0]

  // Board side: owns the matrix rows and the clear request
  modport master (
    output rows, clearEntry,
    input  cols, keyCode, keyValid, keyHeld, entryValue
  );

  // Scanner side
  modport slave (
    input  rows, clearEntry,
    output cols, keyCode, keyValid, keyHeld, entryValue
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 key-matrix scanner. Strobes one column per scan tick,
//               debounces a single press/release on the captured row, and
//               shifts each accepted hex code into a 4-digit entry register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV       = 1024,  // clocks per scan tick
  parameter int DEBOUNCE_TICKS = 8      // stable ticks to accept press/release
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  keypad_scanner_if.slave kp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  logic [3:0]    rs_meta, rs;
  logic [PW-1:0] presc;
  logic          tick;

  state_t        state, state_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [DW-1:0] db_cnt, db_nxt;
  logic [1:0]    low_row;
  logic          row_high;
  logic          accept, release_done;

  logic [3:0]    cols_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;
  logic [15:0]   entry_q;

  // Two-flop synchronizer for the asynchronous row lines (idle = all ones)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= kp.rows;
      rs      <= rs_meta;
    end
  end

  // Prescaler: one-clock tick every SCAN_DIV clocks
  always_ff @(posedge clk) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign row_high = rs[row_idx];

  // Lowest-indexed low row wins when several keys share the active column
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) low_row = 2'(i);
    end
  end

  // FSM state, column, captured row and debounce counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      db_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      col_idx <= col_nxt;
      row_idx <= row_nxt;
      db_cnt  <= db_nxt;
    end
  end

  // Next-state logic; every decision is taken on a scan tick only
  always_comb begin
    state_nxt    = state;
    col_nxt      = col_idx;
    row_nxt      = row_idx;
    db_nxt       = db_cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (&rs) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            row_nxt   = low_row;
            db_nxt    = '0;
            state_nxt = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!row_high) begin
            db_nxt = db_cnt + 1'b1;
            if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            // Bounce: drop back to scanning, outputs untouched
            state_nxt = SCAN;
            col_nxt   = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (row_high) begin
            db_nxt    = '0;
            state_nxt = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (row_high) begin
            db_nxt = db_cnt + 1'b1;
            if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
              release_done = 1'b1;
              state_nxt    = SCAN;
              col_nxt      = col_idx + 2'd1;
            end
          end else begin
            // Row went low again: same key, no new press
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // Registered outputs; clearEntry takes priority over an accept shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cols_q      <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      entry_q     <= 16'h0000;
    end else begin
      cols_q      <= ~(4'b0001 << col_nxt);
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= {row_idx, col_idx};
        key_held_q <= 1'b1;
      end else if (release_done) begin
        key_held_q <= 1'b0;
      end
      if (kp.clearEntry)  entry_q <= 16'h0000;
      else if (accept)    entry_q <= {entry_q[11:0], row_idx, col_idx};
    end
  end

  assign kp.cols       = cols_q;
  assign kp.keyCode    = key_code_q;
  assign kp.keyValid   = key_valid_q;
  assign kp.keyHeld    = key_held_q;
  assign kp.entryValue = entry_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with a 4x4 matrix
//               model, table-driven entry sequence, corner-case sequences and
//               randomized presses checked against a queue-based entry model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pressed;   // pressed[{row,col}] = 1 while that key is down
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.slave)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a row is pulled low by any pressed key on a driven column
  always_comb begin
    kif.rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.cols[c]) kif.rows[r] = 1'b0;
  end

  typedef struct {
    logic [3:0]  key;
    logic [3:0]  exp_code;
    logic [15:0] exp_entry;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] cur_col();
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < 4; i++) if (!kif.cols[i]) c = 2'(i);
    return c;
  endfunction

  // Step until the driven column changes (bounded), so a press lands at a known phase
  task automatic align_col();
    logic [3:0] prev;
    prev = kif.cols;
    for (int i = 0; i < 4*SCAN_DIV; i++) begin
      step();
      if (kif.cols != prev) return;
    end
    chk("align_col_timeout", 32'd0, 32'd1);
  endtask

  // Hold a key mask, then release it; count keyValid pulses across both phases
  task automatic do_press(input logic [15:0] mask, input int hold_clk, input int rel_clk,
                          output int nvalid, output logic [3:0] code,
                          output logic [15:0] entry, output logic held_after);
    nvalid = 0; code = 4'hX; entry = 16'hXXXX;
    pressed = mask;
    for (int i = 0; i < hold_clk + rel_clk; i++) begin
      if (i == hold_clk) pressed = 16'h0;
      step();
      if (kif.keyValid) begin
        nvalid++;
        code  = kif.keyCode;
        entry = kif.entryValue;
      end
    end
    pressed    = 16'h0;
    held_after = kif.keyHeld;
  endtask

  task automatic wait_valid(input int maxc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (kif.keyValid) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_clear();
    kif.clearEntry = 1'b1;
    step();
    kif.clearEntry = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nv, cnt, changes;
    logic [3:0]  code, prev_cols;
    logic [15:0] ent;
    logic        held, seen, held_all;
    logic [1:0]  c;
    logic [3:0]  key;
    logic [3:0]  q[$];
    logic [15:0] exp_entry;

    tbl[0] = '{key: 4'hF, exp_code: 4'hF, exp_entry: 16'h000F};
    tbl[1] = '{key: 4'hA, exp_code: 4'hA, exp_entry: 16'h00FA};
    tbl[2] = '{key: 4'h0, exp_code: 4'h0, exp_entry: 16'h0FA0};
    tbl[3] = '{key: 4'h7, exp_code: 4'h7, exp_entry: 16'hFA07};
    tbl[4] = '{key: 4'h3, exp_code: 4'h3, exp_entry: 16'hA073};

    rst_n = 1'b0;
    kif.clearEntry = 1'b0;
    pressed = 16'h0;
    repeat (3) step();

    // Reset values
    chk("reset_cols",  kif.cols,       4'b1110);
    chk("reset_code",  kif.keyCode,    4'h0);
    chk("reset_valid", kif.keyValid,   1'b0);
    chk("reset_held",  kif.keyHeld,    1'b0);
    chk("reset_entry", kif.entryValue, 16'h0);

    // Idle scan: column n/4 is driven after the n-th edge with rst_n high
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (kif.keyValid) cnt++;
      if (n % 4 == 2) chk("idle_cols", kif.cols, ~(32'd1 << ((n / 4) % 4)) & 32'hF);
    end
    chk("idle_no_valid", cnt, 0);

    // Clean press of row 2 / col 1 for 40 ticks, then release latency
    do_press(16'h1 << 9, 40*SCAN_DIV, 14, nv, code, ent, held);
    chk("clean_nvalid", nv, 1);
    chk("clean_code", code, 4'h9);
    chk("clean_entry", ent, 16'h0009);
    chk("clean_held_early", held, 1'b1);
    repeat (4) step();
    chk("clean_held_released", kif.keyHeld, 1'b0);

    // Table-driven entry sequence F, A, 0, 7, 3
    pulse_clear();
    chk("pre_table_clear", kif.entryValue, 16'h0);
    for (int i = 0; i < 5; i++) begin
      do_press(16'h1 << tbl[i].key, 64, 24, nv, code, ent, held);
      chk("tbl_nvalid", nv, 1);
      chk("tbl_code", code, tbl[i].exp_code);
      chk("tbl_entry", ent, tbl[i].exp_entry);
      chk("tbl_released", held, 1'b0);
    end
    chk("tbl_final_entry", kif.entryValue, 16'hA073);
    pulse_clear();
    chk("tbl_clear", kif.entryValue, 16'h0);

    // Bounce in PRESS_DB: 2 ticks low then high
    align_col();
    c = cur_col();
    do_press(16'h1 << {2'd2, c}, 2*SCAN_DIV, 32, nv, code, ent, held);
    chk("bounce_no_valid", nv, 0);
    chk("bounce_not_held", held, 1'b0);
    changes = 0;
    prev_cols = kif.cols;
    for (int i = 0; i < 6*SCAN_DIV; i++) begin
      step();
      if (kif.cols != prev_cols) changes++;
      prev_cols = kif.cols;
    end
    chk("bounce_scan_resumes", (changes >= 2) ? 1 : 0, 1);

    // 2-tick release glitch while HELD
    pressed = 16'h1 << 5;
    wait_valid(80, seen);
    chk("glitch_first_valid", seen, 1'b1);
    chk("glitch_code", kif.keyCode, 4'h5);
    repeat (8) step();
    nv = 0;
    held_all = 1'b1;
    for (int i = 0; i < 48; i++) begin
      pressed = (i < 2*SCAN_DIV) ? 16'h0 : (16'h1 << 5);
      step();
      if (kif.keyValid) nv++;
      if (!kif.keyHeld) held_all = 1'b0;
    end
    chk("glitch_no_second_valid", nv, 0);
    chk("glitch_held_throughout", held_all, 1'b1);
    do_press(16'h0, 0, 24, nv, code, ent, held);
    chk("glitch_final_release", held, 1'b0);

    // Contention on col 0 (rows 1 and 3) with clearEntry over the accept clock
    kif.clearEntry = 1'b0;
    kif.clearEntry = 1'b1;
    pressed = (16'h1 << 4) | (16'h1 << 12);
    wait_valid(80, seen);
    chk("contend_valid", seen, 1'b1);
    chk("contend_code", kif.keyCode, 4'h4);
    chk("contend_clear_wins", kif.entryValue, 16'h0);
    kif.clearEntry = 1'b0;
    step();
    chk("contend_pulse_width", kif.keyValid, 1'b0);
    chk("contend_entry_after", kif.entryValue, 16'h0);
    do_press(16'h0, 0, 24, nv, code, ent, held);
    chk("contend_release", held, 1'b0);

    // Reset during PRESS_DB, key kept down through and after reset
    align_col();
    c = cur_col();
    key = {2'd3, c};
    pressed = 16'h1 << key;
    repeat (10) step();
    rst_n = 1'b0;
    repeat (2) step();
    chk("midrst_cols",  kif.cols,       4'b1110);
    chk("midrst_valid", kif.keyValid,   1'b0);
    chk("midrst_held",  kif.keyHeld,    1'b0);
    chk("midrst_code",  kif.keyCode,    4'h0);
    chk("midrst_entry", kif.entryValue, 16'h0);
    rst_n = 1'b1;
    wait_valid(80, seen);
    chk("midrst_fresh_valid", seen, 1'b1);
    chk("midrst_fresh_code", kif.keyCode, key);
    chk("midrst_fresh_entry", kif.entryValue, {12'h0, key});
    do_press(16'h0, 0, 24, nv, code, ent, held);
    chk("midrst_release", held, 1'b0);

    // Randomized presses against a queue of the last accepted codes
    pulse_clear();
    q.delete();
    for (int it = 0; it < 16; it++) begin
      key = 4'($urandom_range(0, 15));
      do_press(16'h1 << key, int'($urandom_range(48, 90)), 24, nv, code, ent, held);
      q.push_back(key);
      if (q.size() > 4) void'(q.pop_front());
      exp_entry = 16'h0;
      foreach (q[k]) exp_entry = {exp_entry[11:0], q[k]};
      chk("rand_nvalid", nv, 1);
      chk("rand_code", code, key);
      chk("rand_entry", ent, exp_entry);
      chk("rand_released", held, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        pulse_clear();
        q.delete();
        chk("rand_clear", kif.entryValue, 16'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
